// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Round-robin sharing of the register-file write port among
//            NUM_REQ buffered writeback sources, with a pending-write mask.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        rf_hold,
    output logic                        reg_write,
    output logic [ADDR_W-1:0]           write_register,
    output logic [DATA_W-1:0]           write_data,
    output logic [2:0]                  grant_id,
    output logic [NUM_REGS-1:0]         pending_mask
);

    localparam int               IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   C_NREQ = (IDX_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0]   r_buf_valid;
    logic [ADDR_W-1:0]    r_buf_reg  [NUM_REQ];
    logic [DATA_W-1:0]    r_buf_data [NUM_REQ];
    logic [IDX_W-1:0]     r_rr_last;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_grant_any;
    logic [NUM_REQ-1:0]   w_grant;

    // Rotate the valid vector so bit 0 is the requester just after rr_last,
    // pick the lowest set bit, then map it back to an absolute index.
    always_comb begin
        w_dbl       = {r_buf_valid, r_buf_valid} >> ({1'b0, r_rr_last} + 1'b1);
        w_rot       = w_dbl[NUM_REQ-1:0];
        w_sum       = '0;
        w_grant_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum       = {1'b0, r_rr_last} + 1'b1 + (IDX_W + 1)'(k);
                w_grant_any = ~rf_hold;
            end
        end
        if (w_sum >= C_NREQ) begin
            w_sum = w_sum - C_NREQ;
        end
        w_grant_idx = w_sum[IDX_W-1:0];
        w_grant     = w_grant_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
    end

    assign req_ready = ~r_buf_valid | w_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_buf_reg[i]  <= '0;
                r_buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_reg[i]   <= req_reg[i*ADDR_W +: ADDR_W];
                    r_buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last      <= C_LAST;
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            grant_id       <= '0;
        end else if (w_grant_any) begin
            r_rr_last      <= w_grant_idx;
            reg_write      <= 1'b1;
            write_register <= r_buf_reg[w_grant_idx];
            write_data     <= r_buf_data[w_grant_idx];
            grant_id       <= 3'(w_grant_idx);
        end else begin
            reg_write      <= 1'b0;
        end
    end

    // Derived from buffered/staged state only, never from the request inputs.
    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_buf_valid[i] && (r_buf_reg[i] == ADDR_W'(r))) begin
                    pending_mask[r] = 1'b1;
                end
            end
            if (reg_write && (write_register == ADDR_W'(r))) begin
                pending_mask[r] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (reg_write / write_register / write_data) among NUM_REQ writeback sources, e.g. ALU, load unit and link/jump.
- Each requester has a 1-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write stage.
- Exports a pending-write mask so the decode/stall logic can detect RAW hazards against writes not yet committed.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, register count; width of pending_mask.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request valid.
- req_ready  out  NUM_REQ  per-requester buffer can accept.
- req_reg  in  NUM_REQ*ADDR_W  target register, requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W].
- rf_hold  in  1  when 1, no new grant is issued (debug/stall).
- reg_write  out  1  write enable to register file, registered.
- write_register  out  ADDR_W  register index to register file, registered.
- write_data  out  DATA_W  data to register file, registered.
- grant_id  out  3  index of requester owning the current write stage, registered.
- pending_mask  out  NUM_REGS  bit r=1 while any buffer or the write stage holds a write to r.

Behaviour:
- Reset (async, immediate):
  - all buf_valid=0.
  - reg_write=0, write_register=0, write_data=0, grant_id=0.
  - rr_last=NUM_REQ-1, so requester 0 has first priority.
  - pending_mask=0.
- Buffers: one entry per requester (buf_valid, buf_reg, buf_data).
  - Handshake: req_ready[i] = ~buf_valid[i] | grant[i], combinational.
  - Accept on the rising edge where req_valid[i] & req_ready[i]; the buffer loads req_reg/req_data.
  - Grant and accept in the same cycle: the buffer reloads and buf_valid stays 1.
  - Grant without accept: buf_valid clears.
  - req_valid with req_ready=0 is held by the requester; the block never drops a request.
- Arbitration (combinational, evaluated every cycle):
  - If rf_hold=0 and any buf_valid=1, grant exactly one: the first i with buf_valid[i]=1 scanning rr_last+1, rr_last+2, … modulo NUM_REQ.
  - On grant, rr_last <= i. With no grant, rr_last is unchanged.
- Write stage (registered):
  - On the grant edge: reg_write<=1, write_register<=buf_reg[i], write_data<=buf_data[i], grant_id<=i.
  - With no grant: reg_write<=0; write_register, write_data and grant_id hold their values.
  - The register file commits on the following edge.
- Latency:
  - Accept at edge N, grant at edge N+1 (uncontended, rf_hold=0), RF commit at edge N+2.
  - Sustained throughput is one write per cycle total.
  - A single requester may issue back-to-back requests every cycle when uncontended.
- Fairness: with k requesters continuously pending, each is granted exactly once per k consecutive grants.
- rf_hold=1:
  - No grant, so reg_write deasserts at the next edge.
  - Buffers keep their contents, and req_ready falls for any full buffer.
  - Release resumes round-robin from the unchanged rr_last.
- pending_mask:
  - Bit r = OR over i of (buf_valid[i] & buf_reg[i]==r), OR (reg_write & write_register==r).
  - Combinational from state only; it never depends on req_* inputs.
- Same-register writes:
  - Ordering between different requesters targeting the same register is arbitration order, not issue order.
  - Upstream must not issue two in-flight writes to one register from different sources. pending_mask exists for that check.
  - Per-requester order is preserved.
- Register 0 is not special: writes to index 0 are forwarded unchanged.
- Reset asserted mid-operation: buffered and staged writes are discarded, and no write is issued during or after reset until new requests arrive.
- Requesters with index ≥ NUM_REQ do not exist; grant_id upper bits are 0.

Test Plan:
- Reset, then req_valid[1]=1 with reg=7, data=0xDEADBEEF for one cycle -> edge+1: pending_mask[7]=1. Edge+2: reg_write=1, write_register=7, write_data=0xDEADBEEF, grant_id=1. Edge+3: reg_write=0, pending_mask=0.
- All 3 requesters valid every cycle, writing regs 1/2/3 -> grants cycle 0,1,2,0,1,2…; reg_write stays 1 continuously; req_ready shows each requester accepted once per 3 cycles.
- Requester 0 streams regs 4,5,6 on consecutive cycles alone -> write_register 4,5,6 on consecutive edges; req_ready[0] stays 1.
- Buffers 0 and 2 full, rf_hold=1 for 4 cycles -> reg_write=0, req_ready[0]=req_ready[2]=0, pending_mask holds both registers. Release -> next grants follow round-robin from the prior rr_last.
- Buffer 1 full with reg 9 and write stage active with reg 12, then rst pulsed mid-cycle -> immediately reg_write=0, pending_mask=0, req_ready all 1. No write of reg 9 ever appears.
- Requester 2 writes reg 0 with data 0x1 -> reg_write=1, write_register=0, write_data=0x1, forwarded unchanged.
